// File: rtl/simple_alu_datapath.sv
// Two-stage elastic ALU pipeline: S1 holds the operands and op, S2 holds the result.
// Valid/ready on both sides, plus a busy flag and a count of completed results.
module simple_alu_datapath #(
  parameter int DataWidth = 32,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           alu_config_i,
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [DataWidth-1:0] result_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o,
  input  logic                 clr_cnt_i,
  output logic [CntWidth-1:0]  beat_cnt_o
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpXor = 2'b11;

  logic                 s1_valid_q;
  logic [DataWidth-1:0] s1_a_q;
  logic [DataWidth-1:0] s1_b_q;
  logic [1:0]           s1_op_q;
  logic                 s2_valid_q;
  logic [DataWidth-1:0] s2_result_q;
  logic [CntWidth-1:0]  beat_cnt_q;
  logic [DataWidth-1:0] alu_result;

  logic s1_advance;
  logic in_fire;
  logic out_fire;

  // Ready looks through both stages so a full pipeline still moves at one beat per cycle.
  assign s1_advance = s1_valid_q && (!s2_valid_q || out_ready_i);
  assign in_ready_o = !s1_valid_q || s1_advance;
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = s2_valid_q && out_ready_i;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    alu_result = '0;
    case (s1_op_q)
      OpAdd:   alu_result = s1_a_q + s1_b_q;
      OpSub:   alu_result = s1_a_q - s1_b_q;
      OpMul:   alu_result = s1_a_q * s1_b_q;
      OpXor:   alu_result = s1_a_q ^ s1_b_q;
      default: alu_result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
      end else if (s1_advance) begin
        s1_valid_q <= 1'b0;
      end
      if (s1_advance) begin
        s2_valid_q <= 1'b1;
      end else if (out_fire) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: data registers are reset too because result_o is visible and must read 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OpAdd;
      s2_result_q <= '0;
    end else begin
      if (in_fire) begin
        s1_a_q  <= a_i;
        s1_b_q  <= b_i;
        s1_op_q <= alu_config_i;
      end
      if (s1_advance) begin
        s2_result_q <= alu_result;
      end
    end
  end

  // Clear has priority over a coincident handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q <= '0;
    end else if (clr_cnt_i) begin
      beat_cnt_q <= '0;
    end else if (out_fire) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  assign result_o    = s2_result_q;
  assign out_valid_o = s2_valid_q;
  assign busy_o      = s1_valid_q || s2_valid_q;
  assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: tb/tb_simple_alu_datapath.sv
// Scoreboard bench for simple_alu_datapath: expected results queued at acceptance,
// compared in order at each output handshake; a CntWidth=2 copy checks counter wrap.
module tb_simple_alu_datapath;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [1:0]  alu_cfg;
  logic [31:0] a, b;
  logic        in_valid, in_ready;
  logic [31:0] result;
  logic        out_valid, out_ready;
  logic        busy, clr_cnt;
  logic [15:0] beat_cnt;

  logic        in_ready2, out_valid2, busy2;
  logic [31:0] result2;
  logic [1:0]  beat_cnt2;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] model_cnt = '0;
  bit          rand_done;

  always #5 clk = ~clk;

  simple_alu_datapath #(.DataWidth(32), .CntWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .alu_config_i(alu_cfg), .a_i(a), .b_i(b),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .result_o(result),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy),
    .clr_cnt_i(clr_cnt), .beat_cnt_o(beat_cnt)
  );

  simple_alu_datapath #(.DataWidth(32), .CntWidth(2)) dut_cnt2 (
    .clk_i(clk), .rst_ni(rst_ni), .alu_config_i(alu_cfg), .a_i(a), .b_i(b),
    .in_valid_i(in_valid), .in_ready_o(in_ready2), .result_o(result2),
    .out_valid_o(out_valid2), .out_ready_i(out_ready), .busy_o(busy2),
    .clr_cnt_i(clr_cnt), .beat_cnt_o(beat_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] prod;
    prod = 64'(x) * 64'(y);
    case (op)
      2'b00:   return x + y;
      2'b01:   return x - y;
      2'b10:   return prod[31:0];
      default: return x ^ y;
    endcase
  endfunction

  // Offer one beat; caller is at posedge+1. Returns at posedge+1 after acceptance.
  task automatic send(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] exp);
    bit acc = 1'b0;
    alu_cfg  = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    @(posedge clk);
    if (acc) exp_q.push_back(exp);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_ni = 1'b0;
    exp_q.delete();
    model_cnt = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(beat_cnt), 32'd0);
    check("rst_result", result, 32'd0);
    @(posedge clk);
    #2 rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Cycle monitor: occupancy-derived busy/ready, counter model, in-order result compare.
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(exp_q.size() != 0));
    check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
    check("beat_cnt", 32'(beat_cnt), 32'(model_cnt));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("stray_out", 32'(out_valid), 32'd0);
      else check("result", result, exp_q.pop_front());
    end
    if (clr_cnt) model_cnt = '0;
    else if (out_valid && out_ready) model_cnt = model_cnt + 16'd1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; alu_cfg = 2'b00; a = '0; b = '0;
    in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cnt", 32'(beat_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Add, no stall: latency 2.
    send(2'b00, 32'd3, 32'd5, 32'd8);
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    check("lat_cycle2_result", result, 32'd8);
    @(posedge clk);
    #1;
    check("add_cnt", 32'(beat_cnt), 32'd1);

    // Wrap arithmetic.
    send(2'b01, 32'h0, 32'h1, 32'hFFFF_FFFF);
    send(2'b00, 32'hFFFF_FFFF, 32'h2, 32'h1);
    send(2'b10, 32'h0001_0000, 32'h0001_0000, 32'h0);
    send(2'b11, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0);
    wait_drain();

    // Per-beat op on consecutive cycles.
    send(2'b00, 32'd7, 32'd2, 32'd9);
    send(2'b01, 32'd7, 32'd2, 32'd5);
    send(2'b10, 32'd7, 32'd2, 32'd14);
    send(2'b11, 32'd7, 32'd2, 32'd5);
    check("perbeat_valid3", 32'(out_valid), 32'd1);
    check("perbeat_result3", result, 32'd14);
    @(posedge clk);
    #1;
    check("perbeat_valid4", 32'(out_valid), 32'd1);
    check("perbeat_result4", result, 32'd5);
    wait_drain();

    // Backpressure, plus a config change while the third beat waits.
    out_ready = 1'b0;
    send(2'b00, 32'd1, 32'd1, 32'd2);
    send(2'b01, 32'd9, 32'd4, 32'd5);
    fork
      send(2'b00, 32'd6, 32'd3, 32'd5);
      begin
        repeat (2) @(posedge clk);
        #1 alu_cfg = 2'b11;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_result_held", result, 32'd2);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Counter: 4 handshakes, a 5th, then clear coincident with a 6th.
    pulse_reset();
    for (int i = 0; i < 4; i++) send(2'b00, 32'(i), 32'd1, 32'(i + 1));
    wait_drain();
    check("cnt_after4", 32'(beat_cnt), 32'd4);
    check("cnt2_after4", 32'(beat_cnt2), 32'd0);
    send(2'b11, 32'd5, 32'd5, 32'd0);
    wait_drain();
    check("cnt_after5", 32'(beat_cnt), 32'd5);
    check("cnt2_after5", 32'(beat_cnt2), 32'd1);
    send(2'b00, 32'd10, 32'd20, 32'd30);
    @(posedge clk);
    #1 clr_cnt = 1'b1;
    check("clr_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 clr_cnt = 1'b0;
    check("clr_cnt", 32'(beat_cnt), 32'd0);
    check("clr_cnt2", 32'(beat_cnt2), 32'd0);
    send(2'b00, 32'd1, 32'd2, 32'd3);
    wait_drain();
    check("cnt_pre_rst", 32'(beat_cnt), 32'd1);

    // Reset mid-flight: no stale results afterwards (monitor flags any).
    out_ready = 1'b0;
    send(2'b00, 32'd100, 32'd1, 32'd101);
    send(2'b00, 32'd200, 32'd2, 32'd202);
    pulse_reset();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_cnt", 32'(beat_cnt), 32'd0);

    // Random beats with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          logic [1:0]  op;
          logic [31:0] x, y;
          op = 2'($urandom_range(0, 3));
          x  = $urandom;
          y  = $urandom;
          send(op, x, y, alu_ref(op, x, y));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("rand_cnt", 32'(beat_cnt), 32'd24);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/simple_alu_datapath.md
# simple_alu_datapath

Streaming two-operand ALU that sits directly downstream of the simple ALU CSR manager. It consumes the manager's 2-bit ALU configuration and processes operand pairs from the streamer through a 2-stage elastic pipeline with valid/ready handshakes on both sides. The block also reports a busy flag and counts completed results for software polling.

## Interface
- DataWidth, 32, operand and result width in bits
- CntWidth, 16, width of the completed-result counter
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- alu_config_i  in  2  operation select from the CSR manager: 00 add, 01 sub, 10 mul, 11 xor
- a_i  in  DataWidth  operand A
- b_i  in  DataWidth  operand B
- in_valid_i  in  1  operand pair valid
- in_ready_o  out  1  block accepts operand pair
- result_o  out  DataWidth  result data
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts result
- busy_o  out  1  any pipeline stage holds a valid beat
- clr_cnt_i  in  1  synchronous clear of beat counter
- beat_cnt_o  out  CntWidth  number of results handed off since reset/clear

## Operation
- Input handshake: beat accepted when in_valid_i && in_ready_o.
- Stage 1 (S1) registers a_i, b_i and alu_config_i on acceptance; the op travels with the beat, so a config change affects only beats accepted afterwards.
- Stage 2 (S2) registers the computed result from S1 contents.
- Arithmetic, all modulo 2^DataWidth, unsigned:
  - 00: A + B, carry discarded
  - 01: A - B, borrow discarded (wraps)
  - 10: lower DataWidth bits of A * B
  - 11: A ^ B
- S1 advances when S1 valid and (!S2 valid || out_ready_i).
- in_ready_o = !S1 valid || S1 advances (combinational through both stages; no bubbles at full rate).
- result_o/out_valid_o driven directly from S2 registers; result_o held stable while out_valid_o && !out_ready_i.
- busy_o = S1 valid || S2 valid.
- beat_cnt_o increments by 1 on each output handshake (out_valid_o && out_ready_i), wraps at 2^CntWidth to 0.
- clr_cnt_i sets beat_cnt_o to 0 next cycle; clear wins over a simultaneous handshake (result 0, not 1).
- Data in non-valid stages is don't-care; no register updates on invalid beats required.

## Timing
- Reset values: in_ready_o 1, out_valid_o 0, result_o 0, busy_o 0, beat_cnt_o 0; S1/S2 valids 0.
- Latency: beat accepted in cycle N appears with out_valid_o=1 in cycle N+2 when not stalled.
- Throughput: 1 beat/cycle with out_ready_i held high.
- Capacity: 2 beats in flight; with out_ready_i low, in_ready_o drops once both stages are full; order strictly preserved, no beat dropped or duplicated.
- Full pipeline + out_ready_i high in same cycle: S2 hands off, S1 moves to S2, new beat accepted into S1, all in one cycle.
- Reset asserted mid-operation: all in-flight beats discarded immediately (asynchronous), outputs return to reset values; no result emitted after deassertion for pre-reset beats.
- alu_config_i changing while in_valid_i && !in_ready_o: value sampled at the acceptance edge is used.

## Test plan
- Add, no stall: config 00, A=3, B=5 accepted cycle 0 -> out_valid_o=1, result_o=8 in cycle 2; beat_cnt_o=1 after handshake.
- Wrap arithmetic: sub A=0, B=1 -> 0xFFFFFFFF; add 0xFFFFFFFF+2 -> 1; mul 0x10000*0x10000 -> 0; xor 0xF0F0F0F0^0xFFFF0000 -> 0x0F0FF0F0.
- Per-beat op: back-to-back beats (7,2) with 00, 01, 10, 11 on consecutive cycles -> results 9, 5, 14, 5 on consecutive cycles.
- Backpressure: out_ready_i low 5 cycles while 3 beats offered -> in_ready_o low after 2 accepted, busy_o=1; on release results emerge in order, third beat accepted same cycle the first hands off, none lost.
- Counter: 4 handshakes -> beat_cnt_o=4; clr_cnt_i coincident with a 5th handshake -> beat_cnt_o=0; CntWidth=2 with 5 handshakes -> 1.
- Reset mid-flight: 2 beats in pipeline, pulse rst_ni low -> out_valid_o=0, busy_o=0, beat_cnt_o=0 immediately; no stale result after release.
